// File: rtl/axi_err_slv_sync.sv
// axi_err_slv_sync: terminating AXI4 slave that answers every transaction
// with an error response (Resp on B and R, RespData on R data).
// Write IDs are queued in a MaxTrans-deep FIFO; reads are served one at a time.
// Optional build macro: AXI_ERR_SLV_SYNC_STATS_EN adds saturating error
// counters wr_err_cnt_o / rd_err_cnt_o.
// Reset is synchronous and active-low (rst_ni sampled on clk_i rising edge).

package axi_err_slv_sync_pkg;

    typedef logic [3:0]  id_t;
    typedef logic [31:0] addr_t;
    typedef logic [63:0] data_t;
    typedef logic [7:0]  strb_t;
    typedef logic [0:0]  user_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        user_t      user;
    } ax_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
        user_t      user;
    } b_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_resp_t;

endpackage

module axi_err_slv_sync #(
    parameter type         id_t       = axi_err_slv_sync_pkg::id_t,
    parameter type         axi_req_t  = axi_err_slv_sync_pkg::axi_req_t,
    parameter type         axi_resp_t = axi_err_slv_sync_pkg::axi_resp_t,
    parameter logic [1:0]  Resp       = 2'b11,
    parameter int unsigned DataWidth  = 64,
    parameter logic [63:0] RespData   = 64'hBADC_AB1E,
    parameter int unsigned MaxTrans   = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o
`ifdef AXI_ERR_SLV_SYNC_STATS_EN
    ,
    output logic [31:0] wr_err_cnt_o,
    output logic [31:0] rd_err_cnt_o
`endif
);

    localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int unsigned CntW = $clog2(MaxTrans + 1);
    localparam logic [DataWidth-1:0] RespDataW = DataWidth'(RespData);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    // Pointers wrap at MaxTrans so non-power-of-2 depths work.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(MaxTrans - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // ---------------- write-ID FIFO ----------------
    id_t  id_fifo [MaxTrans];
    ptr_t wr_ptr, rd_ptr;
    cnt_t fifo_cnt;
    logic fifo_full, fifo_empty, push, pop;

    w_state_e w_state, w_state_d;
    logic     w_ready, b_valid;

    assign fifo_full  = (fifo_cnt == cnt_t'(MaxTrans));
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = slv_req_i.aw_valid && !fifo_full;
    assign pop        = b_valid && slv_req_i.b_ready;

    // FIFO pointer and occupancy bookkeeping.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values and updates together.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + cnt_t'(1);
                2'b01:   fifo_cnt <= fifo_cnt - cnt_t'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ID storage written on each AW handshake.
    // NOTE: the storage array is not reset; occupancy lives in the pointers
    // and count, and b.id is masked while no response is pending.
    always_ff @(posedge clk_i) begin
        if (push) id_fifo[wr_ptr] <= slv_req_i.aw.id;
    end

    // ---------------- W / B state machine ----------------
    // W state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) w_state <= W_IDLE;
        else         w_state <= w_state_d;
    end

    // W next state and handshake decodes.
    // NOTE: every output gets a default before the case so no latch forms.
    always_comb begin
        w_state_d = w_state;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        case (w_state)
            W_IDLE: if (!fifo_empty) w_state_d = W_DATA;
            W_DATA: begin
                w_ready = 1'b1;
                if (slv_req_i.w_valid && slv_req_i.w.last) w_state_d = W_RESP;
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (slv_req_i.b_ready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // ---------------- AR / R state machine ----------------
    r_state_e   r_state, r_state_d;
    id_t        r_id_q;
    logic [7:0] r_cnt_q;
    logic       ar_ready, r_valid, r_last, r_load, r_dec;

    assign r_last = r_valid && (r_cnt_q == 8'd0);

    // R state register plus captured ID and remaining-beat counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= R_IDLE;
            r_id_q  <= '0;
            r_cnt_q <= '0;
        end else begin
            r_state <= r_state_d;
            if (r_load) begin
                r_id_q  <= slv_req_i.ar.id;
                r_cnt_q <= slv_req_i.ar.len;
            end else if (r_dec) begin
                r_cnt_q <= r_cnt_q - 8'd1;
            end
        end
    end

    // R next state and handshake decodes.
    always_comb begin
        r_state_d = r_state;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        r_load    = 1'b0;
        r_dec     = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_ready = 1'b1;
                if (slv_req_i.ar_valid) begin
                    r_load    = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                r_valid = 1'b1;
                if (slv_req_i.r_ready) begin
                    if (r_cnt_q == 8'd0) r_state_d = R_IDLE;
                    else                 r_dec     = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Response assembly; payload is zero while idle apart from resp/data.
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = !fifo_full;
        slv_resp_o.ar_ready = ar_ready;
        slv_resp_o.w_ready  = w_ready;
        slv_resp_o.b_valid  = b_valid;
        slv_resp_o.b.id     = b_valid ? id_fifo[rd_ptr] : '0;
        slv_resp_o.b.resp   = Resp;
        slv_resp_o.r_valid  = r_valid;
        slv_resp_o.r.id     = r_valid ? r_id_q : '0;
        slv_resp_o.r.data   = RespDataW;
        slv_resp_o.r.resp   = Resp;
        slv_resp_o.r.last   = r_last;
    end

`ifdef AXI_ERR_SLV_SYNC_STATS_EN
    // Saturating counts of completed error writes (B) and reads (last R).
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_err_cnt_o <= '0;
            rd_err_cnt_o <= '0;
        end else begin
            if (pop && (wr_err_cnt_o != 32'hFFFF_FFFF))
                wr_err_cnt_o <= wr_err_cnt_o + 32'd1;
            if (r_last && slv_req_i.r_ready && (rd_err_cnt_o != 32'hFFFF_FFFF))
                rd_err_cnt_o <= rd_err_cnt_o + 32'd1;
        end
    end
`endif

    // Address, burst, data and strobe fields are deliberately ignored.
    logic unused_req_bits;
    assign unused_req_bits = ^slv_req_i;

endmodule

// File: tb/tb_axi_err_slv_sync.sv
// Self-checking bench for axi_err_slv_sync: a table of transactions plus
// hand-written sequences; B/R beats are checked against scoreboard queues.
module tb_axi_err_slv_sync;
    import axi_err_slv_sync_pkg::*;

    localparam logic [63:0] RESP_DATA = 64'h0000_0000_BADC_AB1E;
    localparam logic [1:0]  DECERR    = 2'b11;

    typedef struct {
        bit         rd;
        id_t        id;
        logic [7:0] len;
        int         exp_cnt;
    } vec_t;

    typedef struct {
        id_t  id;
        logic last;
    } r_exp_t;

    logic      clk = 1'b0;
    logic      rst_n;
    axi_req_t  req;
    axi_resp_t resp;
`ifdef AXI_ERR_SLV_SYNC_STATS_EN
    logic [31:0] wr_cnt, rd_cnt;
`endif

    always #5 clk = ~clk;

    axi_err_slv_sync dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .slv_req_i (req),
        .slv_resp_o(resp)
`ifdef AXI_ERR_SLV_SYNC_STATS_EN
        ,
        .wr_err_cnt_o(wr_cnt),
        .rd_err_cnt_o(rd_cnt)
`endif
    );

    int     n_checks = 0;
    int     n_pass   = 0;
    id_t    b_q[$];
    r_exp_t r_q[$];
    int     b_seen = 0;
    int     r_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare every B and R handshake against the queues.
    always @(negedge clk) begin
        if (rst_n && resp.b_valid && req.b_ready) begin
            check("b_expected", b_q.size() != 0, 1);
            if (b_q.size() != 0) begin
                id_t e;
                e = b_q.pop_front();
                check("b_id", resp.b.id, e);
                check("b_resp", resp.b.resp, DECERR);
            end
            b_seen++;
        end
        if (rst_n && resp.r_valid && req.r_ready) begin
            check("r_expected", r_q.size() != 0, 1);
            if (r_q.size() != 0) begin
                r_exp_t e;
                e = r_q.pop_front();
                check("r_id", resp.r.id, e.id);
                check("r_last", resp.r.last, e.last);
                check("r_data", resp.r.data, RESP_DATA);
                check("r_resp", resp.r.resp, DECERR);
            end
            r_seen++;
        end
    end

    task automatic do_aw(input id_t id);
        req.aw.id    = id;
        req.aw.len   = 8'd5;
        req.aw.addr  = $urandom;
        req.aw_valid = 1'b1;
        b_q.push_back(id);
        for (int i = 0; i < 100; i++) begin
            if (resp.aw_ready) break;
            step();
        end
        check("aw_ready_wait", resp.aw_ready, 1);
        step();
        req.aw_valid = 1'b0;
    endtask

    task automatic do_w(input int beats);
        for (int b = 0; b < beats; b++) begin
            req.w.data  = {$urandom, $urandom};
            req.w.last  = (b == beats - 1);
            req.w_valid = 1'b1;
            for (int i = 0; i < 100; i++) begin
                if (resp.w_ready) break;
                step();
            end
            check("w_ready_wait", resp.w_ready, 1);
            step();
        end
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
    endtask

    task automatic do_ar(input id_t id, input logic [7:0] len);
        req.ar.id    = id;
        req.ar.len   = len;
        req.ar.addr  = $urandom;
        req.ar_valid = 1'b1;
        for (int k = 0; k <= int'(len); k++) r_q.push_back('{id: id, last: (k == int'(len))});
        for (int i = 0; i < 100; i++) begin
            if (resp.ar_ready) break;
            step();
        end
        check("ar_ready_wait", resp.ar_ready, 1);
        step();
        req.ar_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            if (b_q.size() == 0 && r_q.size() == 0) break;
            step();
        end
        check("drain_b", b_q.size(), 0);
        check("drain_r", r_q.size(), 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   b0, r0;

        vecs[0] = '{rd: 1'b0, id: 4'd1,  len: 8'd0,   exp_cnt: 1};
        vecs[1] = '{rd: 1'b0, id: 4'd7,  len: 8'd3,   exp_cnt: 1};
        vecs[2] = '{rd: 1'b1, id: 4'd0,  len: 8'd0,   exp_cnt: 1};
        vecs[3] = '{rd: 1'b1, id: 4'd15, len: 8'd255, exp_cnt: 256};
        vecs[4] = '{rd: 1'b0, id: 4'd14, len: 8'd1,   exp_cnt: 1};
        vecs[5] = '{rd: 1'b1, id: 4'd8,  len: 8'd1,   exp_cnt: 2};
        vecs[6] = '{rd: 1'b0, id: 4'd0,  len: 8'd7,   exp_cnt: 1};

        rst_n = 1'b0;
        req   = '0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        check("rst_aw_ready", resp.aw_ready, 1);
        check("rst_ar_ready", resp.ar_ready, 1);
        check("rst_w_ready", resp.w_ready, 0);
        check("rst_b_valid", resp.b_valid, 0);
        check("rst_r_valid", resp.r_valid, 0);
        check("rst_b_id", resp.b.id, 0);
        check("rst_b_resp", resp.b.resp, DECERR);
        check("rst_r_resp", resp.r.resp, DECERR);
        check("rst_r_data", resp.r.data, RESP_DATA);
        check("rst_r_id", resp.r.id, 0);
        check("rst_r_last", resp.r.last, 0);
        check("rst_users", {resp.b.user, resp.r.user}, 0);

        // Single write: AW id=3, one W beat, B the cycle after
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        b0 = b_seen;
        do_aw(4'd3);
        check("wr_w_ready_lat1", resp.w_ready, 0);
        step();
        check("wr_w_ready_lat2", resp.w_ready, 1);
        req.w_valid = 1'b1;
        req.w.last  = 1'b1;
        step();
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        check("wr_b_valid", resp.b_valid, 1);
        check("wr_b_id", resp.b.id, 3);
        check("wr_w_ready_resp", resp.w_ready, 0);
        step();
        check("wr_b_done", resp.b_valid, 0);
        step();
        step();
        check("wr_one_b", b_seen - b0, 1);

        // Read burst: AR id=5 len=3, four back-to-back beats
        r0 = r_seen;
        do_ar(4'd5, 8'd3);
        for (int i = 0; i < 4; i++) begin
            check("rd_r_valid", resp.r_valid, 1);
            check("rd_ar_ready", resp.ar_ready, 0);
            check("rd_last", resp.r.last, (i == 3));
            step();
        end
        check("rd_r_idle", resp.r_valid, 0);
        check("rd_ar_back", resp.ar_ready, 1);
        check("rd_beats", r_seen - r0, 4);

        // FIFO full: four AWs, no W traffic
        for (int i = 0; i < 4; i++) do_aw(id_t'(i));
        check("full_aw_ready", resp.aw_ready, 0);
        do_w(1);
        check("full_b_valid", resp.b_valid, 1);
        check("full_aw_still0", resp.aw_ready, 0);
        step();
        check("full_aw_back", resp.aw_ready, 1);
        for (int i = 0; i < 3; i++) do_w(1);
        drain();

        // Same-cycle push and pop
        req.b_ready = 1'b0;
        do_aw(4'd2);
        do_w(1);
        check("pp_b_valid", resp.b_valid, 1);
        req.aw.id    = 4'd12;
        req.aw_valid = 1'b1;
        b_q.push_back(4'd12);
        req.b_ready  = 1'b1;
        step();
        req.aw_valid = 1'b0;
        check("pp_b_popped", resp.b_valid, 0);
        check("pp_aw_ready", resp.aw_ready, 1);
        do_w(1);
        drain();

        // Backpressure on both B and R
        req.b_ready = 1'b0;
        req.r_ready = 1'b0;
        do_aw(4'd9);
        do_w(1);
        do_ar(4'd6, 8'd1);
        for (int i = 0; i < 10; i++) begin
            check("bp_b_valid", resp.b_valid, 1);
            check("bp_r_valid", resp.r_valid, 1);
            check("bp_b_id", resp.b.id, 9);
            check("bp_r_id", resp.r.id, 6);
            check("bp_r_last", resp.r.last, 0);
            step();
        end
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        drain();

        // Transaction table, with a read overlapping writes
        for (int v = 0; v < 7; v++) begin
            b0 = b_seen;
            r0 = r_seen;
            if (vecs[v].rd) begin
                do_ar(vecs[v].id, vecs[v].len);
                drain();
                check("vec_r_beats", r_seen - r0, vecs[v].exp_cnt);
            end else begin
                do_aw(vecs[v].id);
                do_w(int'(vecs[v].len) + 1);
                drain();
                check("vec_b_count", b_seen - b0, vecs[v].exp_cnt);
            end
        end
        do_ar(4'd10, 8'd15);
        do_aw(4'd11);
        do_w(2);
        drain();

        // Reset during the second beat of an 8-beat burst
        do_ar(4'd2, 8'd7);
        step();
        check("mid_r_valid", resp.r_valid, 1);
        check("mid_r_last", resp.r.last, 0);
        rst_n       = 1'b0;
        req.r_ready = 1'b0;
        step();
        check("mid_rst_r_valid", resp.r_valid, 0);
        check("mid_rst_ar_ready", resp.ar_ready, 1);
        check("mid_rst_aw_ready", resp.aw_ready, 1);
        check("mid_rst_r_id", resp.r.id, 0);
        r_q.delete();
        rst_n       = 1'b1;
        req.r_ready = 1'b1;
        r0 = r_seen;
        do_ar(4'd4, 8'd1);
        check("mid_new_beat0_last", resp.r.last, 0);
        check("mid_new_id", resp.r.id, 4);
        step();
        check("mid_new_beat1_last", resp.r.last, 1);
        step();
        check("mid_new_idle", resp.r_valid, 0);
        check("mid_new_beats", r_seen - r0, 2);

`ifdef AXI_ERR_SLV_SYNC_STATS_EN
        // Error counters: 3 writes and 2 reads after a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("stats_wr_rst", wr_cnt, 0);
        check("stats_rd_rst", rd_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            do_aw(id_t'(i + 5));
            do_w(1);
        end
        do_ar(4'd1, 8'd2);
        do_ar(4'd2, 8'd0);
        drain();
        step();
        check("stats_wr", wr_cnt, 3);
        check("stats_rd", rd_cnt, 2);
`endif

        drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
